// File: rtl/sseg_reader.sv
// Recovers hex digits from a multiplexed, active-low seven-segment display bus.
// A digit is captured once its strobe+segment pattern has been stable for STABLE_CYCLES samples.
module sseg_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  segs,
    input  logic [3:0]  an,
    input  logic        err_clr,
    output logic [15:0] value,
    output logic [3:0]  dvalid,
    output logic        upd,
    output logic        err_flag
);

    localparam int unsigned SAMPLE_W = 11;
    localparam int unsigned CNT_W    = 8;

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_e;

    state_e              state_q, state_d;
    logic [SAMPLE_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [15:0]         value_q, value_d;
    logic [3:0]          dvalid_q, dvalid_d;
    logic                upd_q, upd_d;
    logic                err_q, err_d;

    logic [SAMPLE_W-1:0] sample_c;
    logic [3:0]          sel_c;
    logic                legal_c;
    logic                capture_c;
    logic [3:0]          nib_c;
    logic                hex_c;
    logic                blank_c;

    assign sample_c = {an, segs};
    assign sel_c    = ~an;
    assign legal_c  = (sel_c != 4'h0) && ((sel_c & (sel_c - 4'd1)) == 4'h0);

    // Active-low glyph decode of the live segment bus
    always_comb begin
        nib_c   = 4'h0;
        hex_c   = 1'b1;
        blank_c = 1'b0;
        case (segs)
            7'h40: nib_c = 4'h0;
            7'h79: nib_c = 4'h1;
            7'h24: nib_c = 4'h2;
            7'h30: nib_c = 4'h3;
            7'h19: nib_c = 4'h4;
            7'h12: nib_c = 4'h5;
            7'h02: nib_c = 4'h6;
            7'h78: nib_c = 4'h7;
            7'h00: nib_c = 4'h8;
            7'h10: nib_c = 4'h9;
            7'h08: nib_c = 4'hA;
            7'h03: nib_c = 4'hB;
            7'h46: nib_c = 4'hC;
            7'h21: nib_c = 4'hD;
            7'h06: nib_c = 4'hE;
            7'h0E: nib_c = 4'hF;
            7'h7F: begin
                hex_c   = 1'b0;
                blank_c = 1'b1;
            end
            default: hex_c = 1'b0;
        endcase
    end

    // Next-state: stability tracking, capture and output update
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        count_d   = count_q;
        value_d   = value_q;
        dvalid_d  = dvalid_q;
        upd_d     = 1'b0;
        err_d     = err_clr ? 1'b0 : err_q;
        capture_c = 1'b0;

        case (state_q)
            SETTLE: begin
                if (sample_c == cand_q) begin
                    count_d = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
                    if ((9'(count_q) + 9'd1) >= 9'(STABLE_CYCLES)) begin
                        capture_c = 1'b1;
                        state_d   = HOLD;
                    end
                end else if (legal_c) begin
                    cand_d  = sample_c;
                    count_d = CNT_W'(1);
                end else begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            IDLE, HOLD: begin
                // HOLD ignores an unchanged sample; any change is handled exactly like IDLE
                if (state_q == IDLE || sample_c != cand_q) begin
                    if (legal_c) begin
                        cand_d  = sample_c;
                        count_d = CNT_W'(1);
                        if (STABLE_CYCLES <= 1) begin
                            capture_c = 1'b1;
                            state_d   = HOLD;
                        end else begin
                            state_d = SETTLE;
                        end
                    end else begin
                        count_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture_c) begin
            upd_d = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (!an[i]) begin
                    dvalid_d[i] = hex_c;
                    if (hex_c) value_d[4*i +: 4] = nib_c;
                end
            end
            if (!hex_c && !blank_c) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cand_q   <= '0;
            count_q  <= '0;
            value_q  <= 16'h0000;
            dvalid_q <= 4'h0;
            upd_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            count_q  <= count_d;
            value_q  <= value_d;
            dvalid_q <= dvalid_d;
            upd_q    <= upd_d;
            err_q    <= err_d;
        end
    end

    assign value    = value_q;
    assign dvalid   = dvalid_q;
    assign upd      = upd_q;
    assign err_flag = err_q;

endmodule

// File: doc/sseg_reader.md
SSEG_READER -- requirements
Module: sseg_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4 (legal range 1..255): consecutive identical samples required before a digit is captured.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port segs  input  7  segment bus, active-low, bit0=a ... bit6=g.
REQ-005 SHALL have port an  input  4  digit strobes, active-low; an[i]=0 selects digit i.
REQ-006 SHALL have port err_clr  input  1  synchronous clear of err_flag.
REQ-007 SHALL have port value  output  16  decoded digits; digit i occupies value[4i+3:4i].
REQ-008 SHALL have port dvalid  output  4  dvalid[i]=1 when digit i holds a legal hex glyph.
REQ-009 SHALL have port upd  output  1  one-cycle pulse on every capture.
REQ-010 SHALL have port err_flag  output  1  sticky illegal-glyph indicator.

Function
REQ-011 SHALL sample segs and an on every rising clk edge; all outputs registered.
REQ-012 SHALL use a state machine with states IDLE, SETTLE, HOLD.
REQ-013 "Strobe legal" SHALL mean exactly one bit of an is 0; every other an value, including 4'hF, is illegal.
REQ-014 IDLE: on a legal strobe, SHALL latch {an,segs} as the candidate, set count=1, and go to SETTLE (capture immediately if STABLE_CYCLES=1, then go to HOLD).
REQ-015 SETTLE: sample equal to candidate -> count+1; on the edge where count reaches STABLE_CYCLES SHALL capture and go to HOLD.
REQ-016 SETTLE: sample differs and strobe legal -> SHALL relatch candidate, count=1, stay in SETTLE; strobe illegal -> IDLE, no capture.
REQ-017 HOLD: SHALL not recapture while sample equals candidate; on change, behaves as IDLE does for that sample.
REQ-018 Latency: segs/an stable from edge t (first sample) -> outputs update at edge t+STABLE_CYCLES-1.
REQ-019 Capture SHALL decode segs (hex, active-low) with 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F.
REQ-020 Legal glyph: SHALL write nibble to digit i, set dvalid[i]=1.
REQ-021 Blank (segs=7F): SHALL clear dvalid[i], leave digit i nibble unchanged.
REQ-022 Any other pattern: SHALL clear dvalid[i], leave nibble unchanged, set err_flag.
REQ-023 Every capture (legal, blank, illegal) SHALL pulse upd high for exactly one cycle; other digits unaffected.
REQ-024 err_clr SHALL clear err_flag next edge; simultaneous illegal capture and err_clr SHALL leave err_flag=1.
REQ-025 count SHALL saturate and never wrap; no capture possible without a change of sample.

Reset
REQ-026 rst=1 SHALL immediately force state=IDLE, count=0, candidate=0, value=16'h0000, dvalid=4'h0, upd=0, err_flag=0.
REQ-027 Reset asserted mid-SETTLE SHALL discard the candidate; first capture after release requires a full STABLE_CYCLES of fresh samples.

Verification
REQ-028 Bench SHALL cover: an=1110, segs=7'h30 held 4 cycles (default) -> value[3:0]=3, dvalid=0001, upd one pulse at 4th sample edge.
REQ-029 Bench SHALL cover: an=1101, segs=7'h08 for 3 cycles then 7'h03 for 4 -> single capture, value[7:4]=B, no capture of A.
REQ-030 Bench SHALL cover: scan digits 0..3 with 7'h40,7'h79,7'h24,7'h0E, 4 cycles each -> value=16'hF210, dvalid=1111, four upd pulses.
REQ-031 Bench SHALL cover: digit 2 segs=7'h55 held 4 cycles -> dvalid[2]=0, err_flag=1; then err_clr same cycle as another 7'h55 capture -> err_flag stays 1.
REQ-032 Bench SHALL cover: an=1100 or an=1111 for 10 cycles -> no upd, outputs unchanged; segs=7'h7F on digit 1 -> dvalid[1]=0, value[7:4] retained.
REQ-033 Bench SHALL cover: rst pulsed asynchronously after 2 of 4 stable samples -> outputs zero instantly; capture only 4 samples after release.
